// File: rtl/red_seq.sv
// Multi-cycle lane reduction: sums all lanes of rs and rt into rd, one lane pair
// per cycle, with signed/unsigned lanes, optional accumulate and overflow flag.

module red_seq_lane #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 8
) (
  input  logic              sgn,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [DATA_W:0]   sum
);
  logic [DATA_W:0] a_ext, b_ext;

  assign a_ext = sgn ? {{(DATA_W+1-LANE_W){a[LANE_W-1]}}, a} : {{(DATA_W+1-LANE_W){1'b0}}, a};
  assign b_ext = sgn ? {{(DATA_W+1-LANE_W){b[LANE_W-1]}}, b} : {{(DATA_W+1-LANE_W){1'b0}}, b};
  assign sum   = a_ext + b_ext;
endmodule

module red_seq #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sgn,
  input  logic              acc,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd,
  output logic              ovf
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state_q, state_d;
  logic [DATA_W-1:0]            rs_q, rt_q, acc_q;
  logic                         sgn_q, ovf_w;
  logic [IW-1:0]                idx_q;
  logic [LANES-1:0][DATA_W:0]   lane_sum;
  logic [DATA_W:0]              acc_ext, sum;
  logic                         ovf_step, last;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    red_seq_lane #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_lane (
      .sgn (sgn_q),
      .a   (rs_q[g*LANE_W +: LANE_W]),
      .b   (rt_q[g*LANE_W +: LANE_W]),
      .sum (lane_sum[g])
    );
  end

  // One extra bit on the running sum exposes both the unsigned carry-out and
  // the signed out-of-range condition for this step.
  assign acc_ext  = sgn_q ? {acc_q[DATA_W-1], acc_q} : {1'b0, acc_q};
  assign sum      = acc_ext + lane_sum[idx_q];
  assign ovf_step = sgn_q ? (sum[DATA_W] ^ sum[DATA_W-1]) : sum[DATA_W];
  assign last     = (idx_q == IW'(LANES-1));
  assign busy     = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q  <= '0;
      rt_q  <= '0;
      acc_q <= '0;
      sgn_q <= 1'b0;
      ovf_w <= 1'b0;
      idx_q <= '0;
      rd    <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          rs_q  <= rs;
          rt_q  <= rt;
          sgn_q <= sgn;
          acc_q <= acc ? rd : '0;
          ovf_w <= 1'b0;
          idx_q <= '0;
        end
        RUN: begin
          acc_q <= sum[DATA_W-1:0];
          ovf_w <= ovf_w | ovf_step;
          idx_q <= idx_q + IW'(1);
          if (last) begin
            rd   <= sum[DATA_W-1:0];
            ovf  <= ovf_w | ovf_step;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_red_seq.sv
// Scoreboard bench for red_seq at the default width and at DATA_W = 32.

module tb_red_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_n16, start16, sgn16, acc16, busy16, done16, ovf16;
  logic [15:0] rs16, rt16, rd16;
  logic        rst_n32, start32, sgn32, acc32, busy32, done32, ovf32;
  logic [31:0] rs32, rt32, rd32;

  red_seq u16 (
    .clk(clk), .rst_n(rst_n16), .start(start16), .sgn(sgn16), .acc(acc16),
    .rs(rs16), .rt(rt16), .busy(busy16), .done(done16), .rd(rd16), .ovf(ovf16)
  );

  red_seq #(.DATA_W(32), .LANE_W(8)) u32 (
    .clk(clk), .rst_n(rst_n32), .start(start32), .sgn(sgn32), .acc(acc32),
    .rs(rs32), .rt(rt32), .busy(busy32), .done(done32), .rd(rd32), .ovf(ovf32)
  );

  logic [64:0] q16[$];
  logic [64:0] q32[$];
  logic [63:0] mrd16 = '0;
  logic [63:0] mrd32 = '0;
  logic        prev_done16 = 1'b0;
  logic        prev_done32 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Integer reference: lanes added pairwise, range-checked then wrapped each step.
  function automatic logic [64:0] model(input int dw, input int lw,
                                        input logic [63:0] a, input logic [63:0] b,
                                        input logic s, input logic ac,
                                        input logic [63:0] prev);
    longint m  = longint'(1) << dw;
    longint lm = longint'(1) << lw;
    longint t, va, vb;
    logic   o = 1'b0;
    logic [63:0] r;
    t = ac ? (longint'(prev) & (m - 1)) : 0;
    if (s && t >= m / 2) t -= m;
    for (int i = 0; i < dw / lw; i++) begin
      va = longint'(a >> (i * lw)) & (lm - 1);
      vb = longint'(b >> (i * lw)) & (lm - 1);
      if (s && va >= lm / 2) va -= lm;
      if (s && vb >= lm / 2) vb -= lm;
      t = t + va + vb;
      if (s ? (t < -(m / 2) || t >= m / 2) : (t >= m)) o = 1'b1;
      t = t & (m - 1);
      if (s && t >= m / 2) t -= m;
    end
    r = 64'(t & (m - 1));
    return {o, r};
  endfunction

  always @(negedge clk) begin
    logic [64:0] e;
    if (done16) begin
      chk("done_dbl16", 64'(prev_done16), 0);
      if (q16.size() == 0) chk("done_unexp16", 64'(done16), 0);
      else begin
        e = q16.pop_front();
        chk("rd16", 64'(rd16), e[63:0]);
        chk("ovf16", 64'(ovf16), 64'(e[64]));
      end
    end
    prev_done16 = done16;
    if (done32) begin
      chk("done_dbl32", 64'(prev_done32), 0);
      if (q32.size() == 0) chk("done_unexp32", 64'(done32), 0);
      else begin
        e = q32.pop_front();
        chk("rd32", 64'(rd32), e[63:0]);
        chk("ovf32", 64'(ovf32), 64'(e[64]));
      end
    end
    prev_done32 = done32;
  end

  // Called at a negedge with the unit idle; returns at the negedge where done is seen.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic ac, input logic poke);
    logic [64:0] e;
    int n = 0, bc = 0;
    start16 = 1'b1; rs16 = a; rt16 = b; sgn16 = s; acc16 = ac;
    e = model(16, 8, 64'(a), 64'(b), s, ac, mrd16);
    mrd16 = e[63:0];
    q16.push_back(e);
    do begin
      @(negedge clk);
      n++;
      if (poke && n == 1) begin
        start16 = 1'b1; rs16 = ~a; rt16 = b ^ 16'h5a5a; sgn16 = ~s; acc16 = ~ac;
      end else start16 = 1'b0;
      if (busy16) bc++;
    end while (!done16 && n < 20);
    if (!done16) chk("timeout16", 64'(done16), 1);
    chk("lat16", 64'(n), 3);
    chk("busy_cyc16", 64'(bc), 2);
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s, input logic ac);
    logic [64:0] e;
    int n = 0;
    start32 = 1'b1; rs32 = a; rt32 = b; sgn32 = s; acc32 = ac;
    e = model(32, 8, 64'(a), 64'(b), s, ac, mrd32);
    mrd32 = e[63:0];
    q32.push_back(e);
    do begin
      @(negedge clk);
      n++;
      start32 = 1'b0;
    end while (!done32 && n < 20);
    if (!done32) chk("timeout32", 64'(done32), 1);
    chk("lat32", 64'(n), 5);
  endtask

  initial begin
    rst_n16 = 1'b0; start16 = 1'b0; sgn16 = 1'b0; acc16 = 1'b0; rs16 = '0; rt16 = '0;
    rst_n32 = 1'b0; start32 = 1'b0; sgn32 = 1'b0; acc32 = 1'b0; rs32 = '0; rt32 = '0;
    #3;
    chk("rst_busy", 64'(busy16), 0);
    chk("rst_done", 64'(done16), 0);
    chk("rst_rd", 64'(rd16), 0);
    chk("rst_ovf", 64'(ovf16), 0);
    chk("rst_rd32", 64'(rd32), 0);
    @(negedge clk);
    rst_n16 = 1'b1; rst_n32 = 1'b1;

    op16(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    chk("unsigned_max", 64'(rd16), 64'h03FC);
    op16(16'h7F80, 16'h7F80, 1'b1, 1'b0, 1'b0);
    chk("signed_m2", 64'(rd16), 64'hFFFE);
    op16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    chk("signed_m4_poked", 64'(rd16), 64'hFFFC);

    // Abandon a run between E0 and E1
    start16 = 1'b1; rs16 = 16'h1234; rt16 = 16'h4321; sgn16 = 1'b0; acc16 = 1'b0;
    @(posedge clk);
    #2;
    rst_n16 = 1'b0; start16 = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy16), 0);
    chk("mid_rst_done", 64'(done16), 0);
    chk("mid_rst_rd", 64'(rd16), 0);
    chk("mid_rst_ovf", 64'(ovf16), 0);
    mrd16 = '0;
    @(negedge clk);
    rst_n16 = 1'b1;
    repeat (4) @(negedge clk);

    op16(16'h0202, 16'h0000, 1'b0, 1'b0, 1'b0);
    op16(16'h0101, 16'h0101, 1'b0, 1'b1, 1'b0);
    chk("acc_8", 64'(rd16), 64'h0008);
    for (int i = 0; i < 32; i++) op16(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    op16(16'h3434, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("acc_7ff0", 64'(rd16), 64'h7FF0);
    for (int i = 0; i < 4; i++) begin
      op16(16'h7F7F, 16'h7F7F, 1'b1, 1'b1, 1'b0);
      if (i == 0) chk("ovf_wrap", 64'(ovf16), 1);
    end
    repeat (3) @(negedge clk);

    op32(32'h01020304, 32'h05060708, 1'b0, 1'b0);
    chk("w32_unsigned", 64'(rd32), 64'h24);
    op32(32'h80808080, 32'h80808080, 1'b1, 1'b0);
    chk("w32_signed", 64'(rd32), 64'hFFFFFC00);
    repeat (3) @(negedge clk);

    chk("q16_drained", 64'(q16.size()), 0);
    chk("q32_drained", 64'(q32.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/red_seq.md
Name: red_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle reduction unit. It sums all LANE_W-bit lanes of two DATA_W-bit source operands, rs and rt, into one DATA_W-bit result. The sum is built one lane-pair per cycle behind a start/busy/done handshake. The unit adds a signed/unsigned lane mode, an accumulate mode (the previous result is added in) and an overflow flag. It sits in the execute stage beside the ALU, and the pipeline stalls while busy is high.

Parameters:
DATA_W, 16, operand and result width in bits; must be a multiple of LANE_W.
LANE_W, 8, lane width in bits; LANES = DATA_W/LANE_W lanes per operand (derived, not overridable).
Legality: LANE_W + clog2(2*LANES) + 1 <= DATA_W, so a non-accumulating reduction never wraps.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a reduction; sampled only in IDLE
sgn  input  1  1 = lanes are two's-complement (sign-extended); 0 = lanes are unsigned (zero-extended)
acc  input  1  1 = the current rd value is the initial accumulator; 0 = the initial accumulator is 0
rs  input  DATA_W  first operand
rt  input  DATA_W  second operand
busy  output  1  high while a reduction is in progress
done  output  1  one-cycle pulse when rd holds the new result
rd  output  DATA_W  result register; holds its value until the next completion
ovf  output  1  sticky-per-operation overflow flag, valid with done and held alongside rd

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, busy = 0, done = 0, rd = 0, ovf = 0, lane index = 0, and the internal accumulator and operand copies = 0. If reset arrives mid-operation, the operation is abandoned and no done pulse follows.
- State machine has two states:
  - IDLE -> RUN on any edge with start = 1.
  - RUN -> IDLE on the edge that processes lane LANES-1.
- Start edge E0 (in IDLE with start = 1):
  - Capture rs, rt, sgn and acc into internal registers.
  - Load accumulator = (acc ? rd : 0); clear the ovf working bit; set lane index = 0.
  - Set busy = 1.
  - Inputs may change freely after E0.
- Each RUN edge k = 1..LANES, processing lane i = k-1:
  - Compute accumulator += ext(rs_cap lane i) + ext(rt_cap lane i). ext is a sign- or zero-extension to DATA_W+1 bits, chosen by the captured sgn.
  - Lane i occupies bits [i*LANE_W +: LANE_W].
  - Advance the lane index.
- Final edge E_LANES:
  - rd <= low DATA_W bits of the accumulator; ovf <= working ovf; done <= 1 (registered); busy <= 0; state = IDLE.
- done timing: done is high for exactly one cycle, from E_LANES to E_LANES+1.
- Latency: start sampled at E0 gives the result visible after E_LANES. This is 2 cycles at the defaults and 4 cycles at DATA_W = 32.
- Width rule: arithmetic is modulo 2^DATA_W, and the result is sign-extended (sgn = 1) or zero-extended (sgn = 0) to DATA_W.
- ovf is set if any add leaves the representable range:
  - sgn = 1: the signed result falls outside [-2^(DATA_W-1), 2^(DATA_W-1)-1], detected by bit DATA_W differing from bit DATA_W-1.
  - sgn = 0: a carry out of bit DATA_W-1 occurs.
  - ovf can only become 1 when acc = 1.
- start while busy = 1 is ignored: no restart and no queuing.
- start on the same edge that done is asserted (state already IDLE after E_LANES) is accepted; back-to-back operations need no bubble beyond that.
- With acc = 1 back-to-back, the accumulator is loaded from the rd value written on the completing edge. This is the just-finished result, not a stale one.
- rd and ovf change only on completion edges and reset.

Test Plan:
- Unsigned reduction, defaults: rs = 0xFFFF, rt = 0xFFFF, sgn = 0, acc = 0 -> busy high for 2 cycles, done pulses once after E2, rd = 0x03FC, ovf = 0.
- Signed reduction, defaults: rs = 0x7F80, rt = 0x7F80, sgn = 1 -> rd = 0xFFFE (-2); repeat with rs = rt = 0xFFFF -> rd = 0xFFFC (-4).
- Accumulate: starting from rd = 0x0004, rs = 0x0101, rt = 0x0101, acc = 1, sgn = 0 -> rd = 0x0008. Then chain four more accumulates from rd = 0x7FF0 with rs = rt = 0x7F7F, sgn = 1 -> ovf = 1 on the wrapping operation.
- Handshake:
  - Pulse start again while busy, with different operands -> ignored and the result is unchanged.
  - Assert start in the done cycle -> the second operation completes 2 cycles later.
  - done is never high for 2 consecutive cycles in a single operation.
- Reset mid-run: drop rst_n asynchronously between E0 and E1 -> busy, done, rd and ovf go to 0 immediately, with no done pulse after release.
- Parameter sweep: DATA_W = 32, LANE_W = 8, rs = 0x01020304, rt = 0x05060708, sgn = 0 -> rd = 0x00000024 and done after E4. With sgn = 1 and rs = rt = 0x80808080 -> rd = 0xFFFFFC00 (-1024).
